// File: rtl/gpio_access_arbiter_if.sv
// Register-port bundle between the two requesters, the arbiter and the GPIO control IP.
// The slave modport is the arbiter's view; the master modport is the requester/GPIO side.
interface gpio_access_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_gnt;
    logic              m0_done;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_gnt;
    logic              m1_done;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_lock;

    logic              gpio_we;
    logic              gpio_re;
    logic [ADDR_W-1:0] gpio_addr;
    logic [DATA_W-1:0] gpio_wdata;
    logic [DATA_W-1:0] gpio_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  gpio_rdata,
        output m0_gnt, m0_done, m0_rdata,
        output m1_gnt, m1_done, m1_rdata,
        output gpio_we, gpio_re, gpio_addr, gpio_wdata
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output gpio_rdata,
        input  m0_gnt, m0_done, m0_rdata,
        input  m1_gnt, m1_done, m1_rdata,
        input  gpio_we, gpio_re, gpio_addr, gpio_wdata
    );
endinterface

// File: rtl/gpio_access_arbiter.sv
// Shares the GPIO register port between M0 (CPU) and M1 (sequencer), one access at a time.
// IDLE -> ISSUE -> RESP: gnt one cycle after req is sampled, done one cycle after gnt.
module gpio_access_arbiter #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_BURST  = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    gpio_access_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q;
    logic              sel_q;
    logic              last_grant_q;
    logic [CNT_W-1:0]  burst_q;
    logic [CNT_W-1:0]  burst_d;
    logic              win_m1_d;
    logic              any_req;
    logic              lock_hold;

    logic              m0_gnt_q, m1_gnt_q;
    logic              m0_done_q, m1_done_q;
    logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;
    logic              gpio_we_q, gpio_re_q;
    logic [ADDR_W-1:0] gpio_addr_q;
    logic [DATA_W-1:0] gpio_wdata_q;

    always_comb begin
        any_req   = bus.m0_req | bus.m1_req;
        // M1 keeps the port on a tie only while it owned it last and its burst budget remains.
        lock_hold = bus.m1_lock & last_grant_q & (burst_q != CNT_W'(MAX_BURST));
        win_m1_d  = bus.m1_req;
        if (bus.m0_req && bus.m1_req) begin
            if (lock_hold) begin
                win_m1_d = 1'b1;
            end else if (FIXED_PRIO != 0) begin
                win_m1_d = 1'b0;
            end else begin
                win_m1_d = ~last_grant_q;
            end
        end

        burst_d = burst_q;
        if (!bus.m1_lock) begin
            burst_d = '0;
        end else if (state_q == IDLE && any_req) begin
            if (!win_m1_d) begin
                burst_d = '0;
            end else if (bus.m0_req) begin
                // Only bursts that starve a waiting M0 are counted.
                burst_d = burst_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
            burst_q      <= '0;
            m0_gnt_q     <= 1'b0;
            m1_gnt_q     <= 1'b0;
            m0_done_q    <= 1'b0;
            m1_done_q    <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            gpio_we_q    <= 1'b0;
            gpio_re_q    <= 1'b0;
            gpio_addr_q  <= '0;
            gpio_wdata_q <= '0;
        end else begin
            m0_gnt_q  <= 1'b0;
            m1_gnt_q  <= 1'b0;
            m0_done_q <= 1'b0;
            m1_done_q <= 1'b0;
            burst_q   <= burst_d;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        sel_q        <= win_m1_d;
                        m0_gnt_q     <= ~win_m1_d;
                        m1_gnt_q     <= win_m1_d;
                        gpio_we_q    <= win_m1_d ? bus.m1_we : bus.m0_we;
                        gpio_re_q    <= win_m1_d ? ~bus.m1_we : ~bus.m0_we;
                        gpio_addr_q  <= win_m1_d ? bus.m1_addr : bus.m0_addr;
                        gpio_wdata_q <= win_m1_d ? bus.m1_wdata : bus.m0_wdata;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (gpio_re_q) begin
                        if (sel_q) begin
                            m1_rdata_q <= bus.gpio_rdata;
                        end else begin
                            m0_rdata_q <= bus.gpio_rdata;
                        end
                    end
                    m0_done_q    <= ~sel_q;
                    m1_done_q    <= sel_q;
                    last_grant_q <= sel_q;
                    gpio_we_q    <= 1'b0;
                    gpio_re_q    <= 1'b0;
                    gpio_addr_q  <= '0;
                    gpio_wdata_q <= '0;
                    state_q      <= RESP;
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.m0_gnt     = m0_gnt_q;
    assign bus.m1_gnt     = m1_gnt_q;
    assign bus.m0_done    = m0_done_q;
    assign bus.m1_done    = m1_done_q;
    assign bus.m0_rdata   = m0_rdata_q;
    assign bus.m1_rdata   = m1_rdata_q;
    assign bus.gpio_we    = gpio_we_q;
    assign bus.gpio_re    = gpio_re_q;
    assign bus.gpio_addr  = gpio_addr_q;
    assign bus.gpio_wdata = gpio_wdata_q;
endmodule
